// File: rtl/redirect_arbiter.sv
// Front-end redirect controller: fixed-priority arbitration of PC redirects, flush/refill
// sequencing with epoch tagging, and re-issue of a redirect whose target never shows up.
module redirect_arbiter #(
  parameter int unsigned NUM_SRC        = 3,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned REFILL_TIMEOUT = 16,
  parameter int unsigned EPOCH_W        = 2,
  parameter logic [31:0] PC_RESET       = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    req_valid_i,
  input  logic [NUM_SRC*32-1:0] req_target_i,
  output logic [NUM_SRC-1:0]    req_ack_o,
  output logic                  redir_valid_o,
  output logic [31:0]           redir_target_o,
  output logic                  flush_o,
  output logic [EPOCH_W-1:0]    epoch_o,
  input  logic                  if_valid_i,
  input  logic [31:0]           if_pc_i,
  output logic                  busy_o,
  output logic                  retry_o
);

  localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned TO_W  = $clog2(REFILL_TIMEOUT);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST    = TO_W'(REFILL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REFILL
  } state_e;

  state_e             state_q, state_d;
  logic [FC_W-1:0]    fcnt_q, fcnt_d;
  logic [TO_W-1:0]    rcnt_q, rcnt_d;
  logic [31:0]        tgt_q, tgt_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               redir_q, redir_d;
  logic               retry_q, retry_d;
  logic               busy_q, busy_d;
  logic               en_q;

  logic [SRC_W-1:0]   win_idx;
  logic [31:0]        win_tgt;
  logic               accept;
  logic               match;

  // Ascending scan so the highest-index requester overwrites lower ones.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_valid_i[i]) win_idx = SRC_W'(i);
    end
    win_tgt = req_target_i[32*win_idx +: 32];
  end

  // en_q keeps acks off during reset and for the first cycle after release.
  assign accept = en_q && (|req_valid_i) && (state_q == S_IDLE || state_q == S_REFILL);
  assign match  = (state_q == S_REFILL) && if_valid_i && (if_pc_i == tgt_q);

  always_comb begin
    state_d   = state_q;
    fcnt_d    = fcnt_q;
    rcnt_d    = rcnt_q;
    tgt_d     = tgt_q;
    epoch_d   = epoch_q;
    redir_d   = 1'b0;
    retry_d   = 1'b0;
    req_ack_o = '0;

    if (accept) begin
      // A fresh request wins over completion or timeout in the same cycle.
      req_ack_o[win_idx] = 1'b1;
      tgt_d   = {win_tgt[31:1], 1'b0};
      redir_d = 1'b1;
      epoch_d = epoch_q + EPOCH_W'(1);
      fcnt_d  = '0;
      state_d = S_FLUSH;
    end else begin
      unique case (state_q)
        S_FLUSH: begin
          if (fcnt_q == FLUSH_LAST) begin
            rcnt_d  = '0;
            state_d = S_REFILL;
          end else begin
            fcnt_d = fcnt_q + FC_W'(1);
          end
        end
        S_REFILL: begin
          if (match) begin
            state_d = S_IDLE;
          end else if (rcnt_q == TO_LAST) begin
            redir_d = 1'b1;
            retry_d = 1'b1;
            epoch_d = epoch_q + EPOCH_W'(1);
            fcnt_d  = '0;
            state_d = S_FLUSH;
          end else begin
            rcnt_d = rcnt_q + TO_W'(1);
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
      tgt_q   <= PC_RESET;
      epoch_q <= '0;
      redir_q <= 1'b0;
      retry_q <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
      tgt_q   <= tgt_d;
      epoch_q <= epoch_d;
      redir_q <= redir_d;
      retry_q <= retry_d;
      busy_q  <= busy_d;
      en_q    <= 1'b1;
    end
  end

  assign redir_valid_o  = redir_q;
  assign redir_target_o = tgt_q;
  assign flush_o        = (state_q == S_FLUSH);
  assign epoch_o        = epoch_q;
  assign busy_o         = busy_q;
  assign retry_o        = retry_q;

endmodule

// File: tb/tb_redirect_arbiter.sv
// Directed bench for redirect_arbiter; a scoreboard queue holds expected redirect target/epoch pairs.
module tb_redirect_arbiter;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] req;
  logic [NS*32-1:0] tgt;
  logic [NS-1:0] ack;
  logic          redir, flush, busy, retry, ifv;
  logic [31:0]   rtgt, ifpc;
  logic [1:0]    epoch;

  logic [NS-1:0] f3_req;
  logic [NS*32-1:0] f3_tgt;
  logic [NS-1:0] f3_ack;
  logic          f3_redir, f3_flush, f3_busy, f3_retry;
  logic [31:0]   f3_rtgt;
  logic [1:0]    f3_epoch;

  typedef struct packed {
    logic [31:0] tgt;
    logic [1:0]  epoch;
  } sb_t;
  sb_t sb_q[$];
  sb_t exp_e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  redirect_arbiter u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req), .req_target_i(tgt), .req_ack_o(ack),
    .redir_valid_o(redir), .redir_target_o(rtgt), .flush_o(flush), .epoch_o(epoch),
    .if_valid_i(ifv), .if_pc_i(ifpc), .busy_o(busy), .retry_o(retry)
  );

  redirect_arbiter #(.FLUSH_CYCLES(3)) u_f3 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(f3_req), .req_target_i(f3_tgt), .req_ack_o(f3_ack),
    .redir_valid_o(f3_redir), .redir_target_o(f3_rtgt), .flush_o(f3_flush), .epoch_o(f3_epoch),
    .if_valid_i(1'b0), .if_pc_i(32'h0), .busy_o(f3_busy), .retry_o(f3_retry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] t, input logic [1:0] e);
    sb_q.push_back('{tgt: t, epoch: e});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  // Scoreboard side: every redirect pulse must match the oldest expected entry.
  always @(posedge clk) begin
    #1;
    if (redir === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_redir", 32'd1, 32'd0);
      end else begin
        exp_e = sb_q.pop_front();
        chk("sb_target", rtgt, exp_e.tgt);
        chk("sb_epoch", {30'd0, epoch}, {30'd0, exp_e.epoch});
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; tgt = '0; ifv = 1'b0; ifpc = '0;
    f3_req = '0; f3_tgt = '0;
    cyc();
    #1;
    chk("rst_ack", {29'd0, ack}, 32'd0);
    chk("rst_redir", {31'd0, redir}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_retry", {31'd0, retry}, 32'd0);
    chk("rst_epoch", {30'd0, epoch}, 32'd0);
    chk("rst_target", rtgt, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single request; bit0 of the target is dropped.
    req = 3'b001; tgt[0+:32] = 32'h41; push(32'h40, 2'd1);
    #1 chk("t1_ack", {29'd0, ack}, 32'b001);
    cyc(); req = '0;
    #1 chk("t1_redir", {31'd0, redir}, 32'd1);
    chk("t1_flush", {31'd0, flush}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_epoch", {30'd0, epoch}, 32'd1);
    cyc(); ifv = 1'b1; ifpc = 32'h40;
    #1 chk("t1_flush_drop", {31'd0, flush}, 32'd0);
    chk("t1_redir_drop", {31'd0, redir}, 32'd0);
    cyc(); ifv = 1'b0;
    #1 chk("t1_idle", {31'd0, busy}, 32'd0);

    // Simultaneous requests, then the loser preempts REFILL while completion also matches.
    do_reset();
    req = 3'b101; tgt[0+:32] = 32'h80; tgt[64+:32] = 32'h100; push(32'h100, 2'd1);
    #1 chk("t2_ack_hi", {29'd0, ack}, 32'b100);
    cyc(); req = 3'b001;
    #1 chk("t2_noack_flush", {29'd0, ack}, 32'd0);
    chk("t2_target1", rtgt, 32'h100);
    cyc(); ifv = 1'b1; ifpc = 32'h100; push(32'h80, 2'd2);
    #1 chk("t2_ack_lo", {29'd0, ack}, 32'b001);
    cyc(); req = '0; ifv = 1'b0;
    #1 chk("t2_preempt_flush", {31'd0, flush}, 32'd1);
    chk("t2_preempt_busy", {31'd0, busy}, 32'd1);
    chk("t2_target2", rtgt, 32'h80);
    cyc(); ifv = 1'b1; ifpc = 32'h80;
    #1 chk("t2_refill", {31'd0, flush}, 32'd0);
    cyc(); ifv = 1'b0;
    #1 chk("t2_idle", {31'd0, busy}, 32'd0);

    // Three-cycle flush instance: a request during FLUSH waits it out.
    f3_req = 3'b001; f3_tgt[0+:32] = 32'h600; f3_tgt[32+:32] = 32'h700;
    #1 chk("t3_ack0", {29'd0, f3_ack}, 32'b001);
    cyc(); f3_req = 3'b010;
    #1 chk("t3_redir", {31'd0, f3_redir}, 32'd1);
    chk("t3_target", f3_rtgt, 32'h600);
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) cyc();
      #1 chk("t3_flush_hold", {31'd0, f3_flush}, 32'd1);
      chk("t3_noack", {29'd0, f3_ack}, 32'd0);
    end
    cyc();
    #1 chk("t3_flush_end", {31'd0, f3_flush}, 32'd0);
    chk("t3_ack1", {29'd0, f3_ack}, 32'b010);
    cyc(); f3_req = '0;
    #1 chk("t3_redir2", {31'd0, f3_redir}, 32'd1);
    chk("t3_target2", f3_rtgt, 32'h700);
    chk("t3_epoch2", {30'd0, f3_epoch}, 32'd2);

    // Stale fetch beats are ignored until the target PC arrives.
    req = 3'b010; tgt[32+:32] = 32'h100; push(32'h100, 2'd3);
    cyc(); req = '0;
    cyc(); ifv = 1'b1; ifpc = 32'h44;
    cyc(); ifpc = 32'h48;
    #1 chk("t4_stale_busy", {31'd0, busy}, 32'd1);
    cyc(); ifpc = 32'h100;
    #1 chk("t4_busy_pre", {31'd0, busy}, 32'd1);
    cyc(); ifv = 1'b0;
    #1 chk("t4_idle", {31'd0, busy}, 32'd0);

    // Timeout re-issue; epoch wraps 3 -> 0 on the first pulse.
    req = 3'b001; tgt[0+:32] = 32'h200; push(32'h200, 2'd0); push(32'h200, 2'd1);
    cyc(); req = '0;
    #1 chk("t5_epoch_wrap", {30'd0, epoch}, 32'd0);
    for (int k = 2; k <= 17; k++) begin
      cyc();
      ifv = (k == 5); ifpc = 32'h204;
      #1 chk("t5_no_retry", {31'd0, retry}, 32'd0);
      chk("t5_refill_noflush", {31'd0, flush}, 32'd0);
    end
    cyc(); ifv = 1'b0;
    #1 chk("t5_retry", {31'd0, retry}, 32'd1);
    chk("t5_reredir", {31'd0, redir}, 32'd1);
    chk("t5_reflush", {31'd0, flush}, 32'd1);
    cyc(); ifv = 1'b1; ifpc = 32'h200;
    #1 chk("t5_retry_pulse", {31'd0, retry}, 32'd0);
    cyc(); ifv = 1'b0;
    #1 chk("t5_idle", {31'd0, busy}, 32'd0);

    // Reset during FLUSH; the held request is acked one cycle after release.
    req = 3'b110; tgt[64+:32] = 32'h300; tgt[32+:32] = 32'h500; push(32'h300, 2'd2);
    #1 chk("t6_ack", {29'd0, ack}, 32'b100);
    cyc(); req = 3'b010;
    #1 chk("t6_flush", {31'd0, flush}, 32'd1);
    rst_n = 1'b0;
    #1 chk("t6_rst_ack", {29'd0, ack}, 32'd0);
    chk("t6_rst_redir", {31'd0, redir}, 32'd0);
    chk("t6_rst_flush", {31'd0, flush}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_retry", {31'd0, retry}, 32'd0);
    chk("t6_rst_epoch", {30'd0, epoch}, 32'd0);
    chk("t6_rst_target", rtgt, 32'h0);
    cyc(); rst_n = 1'b1;
    #1 chk("t6_rel_noack", {29'd0, ack}, 32'd0);
    cyc(); push(32'h500, 2'd1);
    #1 chk("t6_rel_ack", {29'd0, ack}, 32'b010);
    cyc(); req = '0;
    #1 chk("t6_redir", {31'd0, redir}, 32'd1);
    cyc(); ifv = 1'b1; ifpc = 32'h500;
    cyc(); ifv = 1'b0;
    #1 chk("t6_idle", {31'd0, busy}, 32'd0);

    cyc();
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
